pst_fetch: RTL and testbench

Pipelined instruction-fetch stage with its IF/ID pipeline register, directly upstream of the instruction-decode stage. Holds the PC and drives the word address of the combinational instruction ROM. Each cycle it latches the fetched word into IF/ID. It handles stall, flush and redirect requests from later stages, and a RUN/HALTED state machine for syscall exit. Fetch and bubble counters are kept for the debug display.

---
 rtl/pst_fetch.sv | 95 +++++++++
 tb/tb_pst_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pst_fetch.sv
// Instruction-fetch stage: PC register, ROM word addressing and the IF/ID
// pipeline register, with stall/flush/redirect handling and a RUN/HALTED FSM.
module pst_fetch #(
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter int          IM_ADDR_BITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  input  logic                    halt,
  input  logic                    resume,
  output logic [IM_ADDR_BITS-1:0] im_addr,
  input  logic [31:0]             im_data,
  output logic [31:0]             inst,
  output logic [31:0]             pc_id,
  output logic [31:0]             pc4_id,
  output logic                    valid_id,
  output logic [31:0]             pc,
  output logic                    halted,
  output logic [31:0]             cnt_fetch,
  output logic [31:0]             cnt_bubble
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state;
  logic [31:0] pc_next4;
  logic        unused_bits;

  // Word-aligned ROM addressing; upper PC bits alias so the ROM wraps.
  assign im_addr     = pc[IM_ADDR_BITS+1:2];
  assign pc_next4    = pc + 32'd4;
  assign halted      = (state == HALTED);
  assign unused_bits = ^redirect_pc[1:0];

  // ---- IF -> ID boundary: PC, IF/ID register, FSM and counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= PC_RESET;
      inst       <= '0;
      pc_id      <= '0;
      pc4_id     <= '0;
      valid_id   <= 1'b0;
      state      <= RUN;
      cnt_fetch  <= '0;
      cnt_bubble <= '0;
    end else if (en) begin
      if (state == HALTED) begin
        // halt wins over a simultaneous resume
        if (resume && !halt) state <= RUN;
      end else if (halt) begin
        state      <= HALTED;
        inst       <= '0;
        pc_id      <= '0;
        pc4_id     <= '0;
        valid_id   <= 1'b0;
        cnt_bubble <= cnt_bubble + 32'd1;
      end else if (redirect_valid) begin
        pc         <= {redirect_pc[31:2], 2'b00};
        inst       <= '0;
        pc_id      <= '0;
        pc4_id     <= '0;
        valid_id   <= 1'b0;
        cnt_bubble <= cnt_bubble + 32'd1;
      end else if (stall) begin
        if (flush) begin
          inst       <= '0;
          pc_id      <= '0;
          pc4_id     <= '0;
          valid_id   <= 1'b0;
          cnt_bubble <= cnt_bubble + 32'd1;
        end
      end else if (flush) begin
        pc         <= pc_next4;
        inst       <= '0;
        pc_id      <= '0;
        pc4_id     <= '0;
        valid_id   <= 1'b0;
        cnt_bubble <= cnt_bubble + 32'd1;
      end else begin
        pc        <= pc_next4;
        inst      <= im_data;
        pc_id     <= pc;
        pc4_id    <= pc_next4;
        valid_id  <= 1'b1;
        cnt_fetch <= cnt_fetch + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pst_fetch.sv
// Directed, table-driven bench for pst_fetch with a ROM returning 0x20080001 + pc.
module tb_pst_fetch;

  localparam logic [31:0] PC_RST = 32'h0040_0000;
  localparam int          AB     = 10;

  logic          clk = 1'b0;
  logic          rst, en, stall, flush, redirect_valid, halt, resume;
  logic [31:0]   redirect_pc;
  logic [AB-1:0] im_addr;
  logic [31:0]   im_data, inst, pc_id, pc4_id, pc, cnt_fetch, cnt_bubble;
  logic          valid_id, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign im_data = 32'h2008_0001 + pc;

  pst_fetch #(.PC_RESET(PC_RST), .IM_ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .resume(resume), .im_addr(im_addr), .im_data(im_data),
    .inst(inst), .pc_id(pc_id), .pc4_id(pc4_id), .valid_id(valid_id),
    .pc(pc), .halted(halted), .cnt_fetch(cnt_fetch), .cnt_bubble(cnt_bubble)
  );

  typedef struct {
    logic        stall, flush, rv;
    logic [31:0] rpc;
    logic        halt, resume;
    logic [31:0] e_pc, e_inst, e_pc_id;
    logic        e_valid, e_halted;
    logic [31:0] e_fetch, e_bubble;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic f, logic rv, logic [31:0] rpc,
                              logic h, logic r, logic [31:0] epc, logic [31:0] einst,
                              logic [31:0] epcid, logic ev, logic eh,
                              logic [31:0] ef, logic [31:0] eb);
    vec_t v;
    v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc; v.halt = h; v.resume = r;
    v.e_pc = epc; v.e_inst = einst; v.e_pc_id = epcid; v.e_valid = ev;
    v.e_halted = eh; v.e_fetch = ef; v.e_bubble = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = '0; halt = 0; resume = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] s_pc, s_inst, s_pc_id, s_pc4, s_f, s_b;
  logic        s_v, s_h;
  logic [31:0] e_pc4, e_addr;

  initial begin
    // stall flush rv rpc halt resume | pc inst pc_id valid halted fetch bubble
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h0040_0004, 32'h2048_0001, 32'h0040_0000, 1,0, 1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h0040_0008, 32'h2048_0005, 32'h0040_0004, 1,0, 2,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h0040_000C, 32'h2048_0009, 32'h0040_0008, 1,0, 3,0));
    vecs.push_back(mk(0,0,1,32'h0C,0,0, 32'h0C, 32'h0, 32'h0, 0,0, 3,1));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h10, 32'h2008_000D, 32'h0C, 1,0, 4,1));
    vecs.push_back(mk(1,0,0,32'h0,0,0, 32'h10, 32'h2008_000D, 32'h0C, 1,0, 4,1));
    vecs.push_back(mk(1,0,0,32'h0,0,0, 32'h10, 32'h2008_000D, 32'h0C, 1,0, 4,1));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h14, 32'h2008_0011, 32'h10, 1,0, 5,1));
    vecs.push_back(mk(1,0,1,32'h103,0,0, 32'h100, 32'h0, 32'h0, 0,0, 5,2));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h104, 32'h2008_0101, 32'h100, 1,0, 6,2));
    vecs.push_back(mk(1,1,0,32'h0,0,0, 32'h104, 32'h0, 32'h0, 0,0, 6,3));
    vecs.push_back(mk(0,1,0,32'h0,0,0, 32'h108, 32'h0, 32'h0, 0,0, 6,4));
    vecs.push_back(mk(0,0,1,32'h1C,0,0, 32'h1C, 32'h0, 32'h0, 0,0, 6,5));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h20, 32'h2008_001D, 32'h1C, 1,0, 7,5));
    vecs.push_back(mk(1,1,1,32'h300,1,0, 32'h20, 32'h0, 32'h0, 0,1, 7,6));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h20, 32'h0, 32'h0, 0,1, 7,6));
    vecs.push_back(mk(0,0,0,32'h0,1,0, 32'h20, 32'h0, 32'h0, 0,1, 7,6));
    vecs.push_back(mk(0,0,0,32'h0,1,1, 32'h20, 32'h0, 32'h0, 0,1, 7,6));
    vecs.push_back(mk(0,0,1,32'h400,0,0, 32'h20, 32'h0, 32'h0, 0,1, 7,6));
    vecs.push_back(mk(1,1,0,32'h0,0,0, 32'h20, 32'h0, 32'h0, 0,1, 7,6));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 32'h20, 32'h0, 32'h0, 0,0, 7,6));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h24, 32'h2008_0021, 32'h20, 1,0, 8,6));
    vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0,0, 8,7));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 32'h0, 32'h2007_FFFD, 32'hFFFF_FFFC, 1,0, 9,7));

    // Reset
    rst = 1; en = 1; idle_inputs();
    step();
    chk("rst_pc", pc, PC_RST);
    chk("rst_im_addr", im_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_pc4_id", pc4_id, 32'h0);
    chk("rst_valid", valid_id, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fetch", cnt_fetch, 32'h0);
    chk("rst_bubble", cnt_bubble, 32'h0);
    rst = 0;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; flush = vecs[i].flush; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; halt = vecs[i].halt; resume = vecs[i].resume;
      step();
      e_pc4  = vecs[i].e_valid ? vecs[i].e_pc_id + 32'd4 : 32'h0;
      e_addr = {22'h0, vecs[i].e_pc[AB+1:2]};
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_im_addr", i), im_addr, e_addr);
      chk($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
      chk($sformatf("v%0d_pc_id", i), pc_id, vecs[i].e_pc_id);
      chk($sformatf("v%0d_pc4_id", i), pc4_id, e_pc4);
      chk($sformatf("v%0d_valid", i), valid_id, vecs[i].e_valid);
      chk($sformatf("v%0d_halted", i), halted, vecs[i].e_halted);
      chk($sformatf("v%0d_fetch", i), cnt_fetch, vecs[i].e_fetch);
      chk($sformatf("v%0d_bubble", i), cnt_bubble, vecs[i].e_bubble);
    end

    // en low for 3 cycles freezes everything, even with active requests
    s_pc = 32'h0; s_inst = 32'h2007_FFFD; s_pc_id = 32'hFFFF_FFFC; s_pc4 = 32'h0;
    s_v = 1'b1; s_h = 1'b0; s_f = 32'd9; s_b = 32'd7;
    en = 0; redirect_valid = 1; redirect_pc = 32'h500; halt = 1; flush = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("en0_%0d_pc", k), pc, s_pc);
      chk($sformatf("en0_%0d_inst", k), inst, s_inst);
      chk($sformatf("en0_%0d_pc_id", k), pc_id, s_pc_id);
      chk($sformatf("en0_%0d_pc4_id", k), pc4_id, s_pc4);
      chk($sformatf("en0_%0d_valid", k), valid_id, s_v);
      chk($sformatf("en0_%0d_halted", k), halted, s_h);
      chk($sformatf("en0_%0d_fetch", k), cnt_fetch, s_f);
      chk($sformatf("en0_%0d_bubble", k), cnt_bubble, s_b);
    end

    // Halt, then reset while HALTED with en low
    en = 1; idle_inputs(); halt = 1;
    step();
    chk("halt2_halted", halted, 1'b1);
    chk("halt2_bubble", cnt_bubble, 32'd8);
    halt = 0; en = 0; rst = 1;
    step();
    chk("rsth_halted", halted, 1'b0);
    chk("rsth_fetch", cnt_fetch, 32'h0);
    chk("rsth_bubble", cnt_bubble, 32'h0);
    chk("rsth_pc", pc, PC_RST);
    chk("rsth_valid", valid_id, 1'b0);
    rst = 0; en = 1;
    step();
    chk("post_rst_inst", inst, 32'h2048_0001);
    chk("post_rst_pc", pc, 32'h0040_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
